// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [31:0] FAULT_INST = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// Bus watchdog: counts cycles spent waiting on the bus and flags expiry at TIMEOUT.
module ifetch_wdog
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Expiry fires in the cycle whose increment brings the count to TIMEOUT.
  assign expired = active && (count == CW'(TIMEOUT - 1));

  // Cycle counter, restarted on every new bus request.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (active && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC request -> single-beat bus read -> IDU handoff.
// Defining IFETCH_TIMEOUT_EN adds the ifetch_wdog bus watchdog.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             fault
);

  state_t           state;
  logic [WIDTH-1:0] addr_q;
  logic             expired;

  assign araddr  = addr_q;
  assign inst_pc = addr_q;

`ifdef IFETCH_TIMEOUT_EN
  logic wdog_start;
  logic wdog_active;

  assign wdog_start  = (state == IDLE) && pc_valid && !is_misaligned(pc[1:0]);
  assign wdog_active = (state == ADDR) || (state == DATA);

  ifetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .start   (wdog_start),
    .active  (wdog_active),
    .expired (expired)
  );
`else
  // Without the watchdog the bus is waited on indefinitely; TIMEOUT has no effect.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  // Fetch FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      inst       <= FAULT_INST;
      fault      <= 1'b0;
      pc_ready   <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid) begin
            addr_q   <= pc;
            pc_ready <= 1'b0;
            if (is_misaligned(pc[1:0])) begin
              inst       <= FAULT_INST;
              fault      <= 1'b1;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              arvalid <= 1'b1;
              state   <= ADDR;
            end
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end else if (expired) begin
            arvalid    <= 1'b0;
            inst       <= FAULT_INST;
            fault      <= 1'b1;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            state <= ADDR;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst       <= rdata;
            fault      <= (rresp != RESP_OKAY);
            inst_valid <= 1'b1;
            state      <= HOLD;
          end else if (expired) begin
            rready     <= 1'b0;
            inst       <= FAULT_INST;
            fault      <= 1'b1;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            state <= DATA;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            pc_ready   <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state      <= IDLE;
          pc_ready   <= 1'b1;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning bus watchdog limit in cycles.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports pc_valid in 1, pc_ready out 1, pc in WIDTH: fetch request from the PC stage.
REQ-006 SHALL have ports araddr out WIDTH, arvalid out 1, arready in 1: bus read address channel.
REQ-007 SHALL have ports rdata in 32, rresp in 2, rvalid in 1, rready out 1: bus read data channel.
REQ-008 SHALL have ports inst out 32, inst_pc out WIDTH, inst_valid out 1, inst_ready in 1: instruction handoff to the IDU.
REQ-009 SHALL have port fault out 1: access fault, qualified by inst_valid.

Function
REQ-010 SHALL implement FSM IDLE, ADDR, DATA, HOLD.
REQ-011 IDLE: pc_ready=1; on pc_valid, SHALL latch pc into addr_q and go to ADDR.
REQ-012 In IDLE with pc_valid and pc[1:0]!=0, SHALL skip the bus, set inst=0 and fault=1, and go to HOLD.
REQ-013 ADDR: arvalid=1, araddr=addr_q held stable; on arready SHALL go to DATA.
REQ-014 DATA: rready=1; on rvalid SHALL latch rdata into inst, set fault=(rresp!=2'b00), and go to HOLD.
REQ-015 HOLD: inst_valid=1 with inst, inst_pc=addr_q and fault stable; on inst_ready SHALL go to IDLE.
REQ-016 pc_ready SHALL be 1 only in IDLE; arvalid only in ADDR; rready only in DATA; inst_valid only in HOLD.
REQ-017 With arready and rvalid asserted immediately, minimum latency from pc handshake (cycle 0) to inst_valid SHALL be 3 cycles.
REQ-018 Back-to-back fetches SHALL cost one IDLE cycle between inst_ready and the next pc handshake.
REQ-019 If arvalid is high and arready is low, arvalid and araddr SHALL remain unchanged until arready.
REQ-020 Any rvalid outside DATA SHALL be ignored.

Reset
REQ-021 rst SHALL force the state to IDLE, inst=0, inst_pc=0, fault=0, and addr_q=0.
REQ-022 rst mid-transaction SHALL drop arvalid and rready in the following cycle, with no completion delivered.
REQ-023 Out of reset, pc_ready=1, arvalid=0, rready=0, inst_valid=0.

Configuration
REQ-024 With IFETCH_TIMEOUT_EN defined: a counter SHALL clear on entry to ADDR and increment each cycle in ADDR or DATA.
REQ-025 With IFETCH_TIMEOUT_EN defined: when that counter reaches TIMEOUT, the block SHALL go to HOLD with inst=0 and fault=1.
REQ-026 With IFETCH_TIMEOUT_EN undefined: no counter SHALL exist, and the block SHALL wait indefinitely for arready and rvalid.

Structure
REQ-027 Shared package ifetch_pkg SHALL hold the state enum, RESP_OKAY=2'b00, and FAULT_INST=32'h0.
REQ-028 The watchdog SHALL be sub-module ifetch_wdog, instantiated only under IFETCH_TIMEOUT_EN.

Verification
REQ-029 pc=0x80000000, arready=1, rvalid=1 immediately, rdata=0x00000413 -> inst_valid at cycle 3 with inst=0x00000413, inst_pc=0x80000000, fault=0.
REQ-030 arready held low 5 cycles -> arvalid high and araddr stable all 5 cycles; inst_valid 1 cycle after rvalid.
REQ-031 pc=0x80000002 -> no arvalid ever; inst_valid next cycle with fault=1, inst=0.
REQ-032 rresp=2'b10 with rdata=0xDEADBEEF -> inst=0xDEADBEEF, fault=1.
REQ-033 inst_ready low 4 cycles in HOLD -> outputs stable and pc_ready=0; after inst_ready, pc_ready=1 next cycle.
REQ-034 rst asserted in DATA -> rready=0 and state IDLE next cycle; with IFETCH_TIMEOUT_EN and TIMEOUT=8 and rvalid never asserted -> fault=1 after 8 cycles.
